// File: rtl/death_sequencer.sv
// Death/respawn sequencer: one blast-zone channel per player, both channels
// stepped by the shared frame_tick and cleared whenever game_active is low.

module death_seq_channel #(
  parameter logic [9:0]  X_MIN          = 10'd8,
  parameter logic [9:0]  X_MAX          = 10'd631,
  parameter logic [9:0]  Y_MAX          = 10'd471,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned INVULN_FRAMES  = 90,
  parameter int unsigned CW             = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick_i,
  input  logic       game_active_i,
  input  logic [9:0] pos_x_i,
  input  logic [9:0] pos_y_i,
  output logic       death_o,
  output logic       respawn_o,
  output logic       hidden_o,
  output logic       invuln_o
);

  typedef enum logic [2:0] {
    ST_ALIVE  = 3'd0,
    ST_DEAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_SPAWN  = 3'd3,
    ST_INVULN = 3'd4
  } state_e;

  // A zero respawn delay still needs one frame in WAIT.
  localparam logic [CW-1:0] RESP_LOAD  = (RESPAWN_FRAMES == 0) ? CW'(1) : CW'(RESPAWN_FRAMES);
  localparam logic [CW-1:0] INV_LOAD   = CW'(INVULN_FRAMES);
  localparam logic [CW-1:0] CNT_ONE    = CW'(1);
  localparam logic          HAS_INVULN = (INVULN_FRAMES != 0);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          death_q, respawn_q, hidden_q, invuln_q;
  logic          oob_s;

  assign oob_s = (pos_x_i < X_MIN) || (pos_x_i > X_MAX) || (pos_y_i > Y_MAX);

  // State and frame counter registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_ALIVE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and counter update.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!game_active_i) begin
      state_d = ST_ALIVE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_ALIVE: begin
          if (frame_tick_i && oob_s) begin
            state_d = ST_DEAD;
          end else begin
            state_d = ST_ALIVE;
          end
        end
        ST_DEAD: begin
          state_d = ST_WAIT;
          cnt_d   = RESP_LOAD;
        end
        ST_WAIT: begin
          if (frame_tick_i) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_SPAWN;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        ST_SPAWN: begin
          if (HAS_INVULN) begin
            state_d = ST_INVULN;
            cnt_d   = INV_LOAD;
          end else begin
            state_d = ST_ALIVE;
            cnt_d   = '0;
          end
        end
        ST_INVULN: begin
          if (frame_tick_i) begin
            if (cnt_q == CNT_ONE) begin
              state_d = ST_ALIVE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q;
          end
        end
        default: begin
          state_d = ST_ALIVE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // Outputs decode the current state one cycle late; forced quiet while the game is stopped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      death_q   <= 1'b0;
      respawn_q <= 1'b0;
      hidden_q  <= 1'b0;
      invuln_q  <= 1'b0;
    end else if (!game_active_i) begin
      death_q   <= 1'b0;
      respawn_q <= 1'b0;
      hidden_q  <= 1'b0;
      invuln_q  <= 1'b0;
    end else begin
      death_q   <= (state_q == ST_DEAD);
      respawn_q <= (state_q == ST_SPAWN);
      hidden_q  <= (state_q == ST_DEAD) || (state_q == ST_WAIT) || (state_q == ST_SPAWN);
      invuln_q  <= (state_q == ST_INVULN);
    end
  end

  assign death_o   = death_q;
  assign respawn_o = respawn_q;
  assign hidden_o  = hidden_q;
  assign invuln_o  = invuln_q;

endmodule

module death_sequencer #(
  parameter logic [9:0]  X_MIN          = 10'd8,
  parameter logic [9:0]  X_MAX          = 10'd631,
  parameter logic [9:0]  Y_MAX          = 10'd471,
  parameter int unsigned RESPAWN_FRAMES = 120,
  parameter int unsigned INVULN_FRAMES  = 90,
  parameter int unsigned CW             = 8
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       frame_tick,
  input  logic       game_active,
  input  logic [9:0] c1x,
  input  logic [9:0] c1y,
  input  logic [9:0] c2x,
  input  logic [9:0] c2y,
  output logic       death_1,
  output logic       death_2,
  output logic       respawn_1,
  output logic       respawn_2,
  output logic       hidden_1,
  output logic       hidden_2,
  output logic       invuln_1,
  output logic       invuln_2
);

  death_seq_channel #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .RESPAWN_FRAMES(RESPAWN_FRAMES), .INVULN_FRAMES(INVULN_FRAMES), .CW(CW)
  ) u_ch1 (
    .clk(clk), .reset_n(reset_n), .frame_tick_i(frame_tick), .game_active_i(game_active),
    .pos_x_i(c1x), .pos_y_i(c1y),
    .death_o(death_1), .respawn_o(respawn_1), .hidden_o(hidden_1), .invuln_o(invuln_1)
  );

  death_seq_channel #(
    .X_MIN(X_MIN), .X_MAX(X_MAX), .Y_MAX(Y_MAX),
    .RESPAWN_FRAMES(RESPAWN_FRAMES), .INVULN_FRAMES(INVULN_FRAMES), .CW(CW)
  ) u_ch2 (
    .clk(clk), .reset_n(reset_n), .frame_tick_i(frame_tick), .game_active_i(game_active),
    .pos_x_i(c2x), .pos_y_i(c2y),
    .death_o(death_2), .respawn_o(respawn_2), .hidden_o(hidden_2), .invuln_o(invuln_2)
  );

endmodule

// File: tb/tb_death_sequencer.sv
// Bench for death_sequencer: default build plus a RESPAWN_FRAMES=0/INVULN_FRAMES=0
// build driven in parallel, checked by vector table, directed sequences and a timeline model.

module tb_death_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, frame_tick, game_active;
  logic [9:0] c1x, c1y, c2x, c2y;
  logic death_1, death_2, respawn_1, respawn_2, hidden_1, hidden_2, invuln_1, invuln_2;
  logic b_death_1, b_death_2, b_respawn_1, b_respawn_2, b_hidden_1, b_hidden_2, b_invuln_1, b_invuln_2;

  death_sequencer dut (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .game_active(game_active),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
    .death_1(death_1), .death_2(death_2), .respawn_1(respawn_1), .respawn_2(respawn_2),
    .hidden_1(hidden_1), .hidden_2(hidden_2), .invuln_1(invuln_1), .invuln_2(invuln_2)
  );

  death_sequencer #(.RESPAWN_FRAMES(0), .INVULN_FRAMES(0)) dut_b (
    .clk(clk), .reset_n(reset_n), .frame_tick(frame_tick), .game_active(game_active),
    .c1x(c1x), .c1y(c1y), .c2x(c2x), .c2y(c2y),
    .death_1(b_death_1), .death_2(b_death_2), .respawn_1(b_respawn_1), .respawn_2(b_respawn_2),
    .hidden_1(b_hidden_1), .hidden_2(b_hidden_2), .invuln_1(b_invuln_1), .invuln_2(b_invuln_2)
  );

  int total = 0;
  int bad   = 0;
  int e     = 0;

  // Timeline model: a life is described by the edge it died at, the edge its
  // respawn fired at, and how many frames have elapsed in each waiting window.
  int dead_e[4], spawn_e[4], nw[4], ni[4];
  int rf[4]  = '{120, 120, 1, 1};
  int inf[4] = '{90, 90, 0, 0};
  logic [3:0] exp_v[4];

  function automatic bit oob(int k);
    int x, y;
    x = (k % 2 == 0) ? int'(c1x) : int'(c2x);
    y = (k % 2 == 0) ? int'(c1y) : int'(c2y);
    return (x < 8) || (x > 631) || (y > 471);
  endfunction

  // {death, respawn, hidden, invuln} shown for the cycle following edge c
  function automatic logic [3:0] view(int k, int c);
    if (dead_e[k] < 0) return 4'b0000;
    if (c == dead_e[k]) return 4'b1010;
    if (spawn_e[k] < 0) return 4'b0010;
    if (c == spawn_e[k]) return 4'b0110;
    return 4'b0001;
  endfunction

  function automatic logic [3:0] act(int k);
    case (k)
      0: return {death_1, respawn_1, hidden_1, invuln_1};
      1: return {death_2, respawn_2, hidden_2, invuln_2};
      2: return {b_death_1, b_respawn_1, b_hidden_1, b_invuln_1};
      default: return {b_death_2, b_respawn_2, b_hidden_2, b_invuln_2};
    endcase
  endfunction

  task automatic model_clear();
    for (int k = 0; k < 4; k++) begin
      dead_e[k] = -1; spawn_e[k] = -1; nw[k] = 0; ni[k] = 0;
    end
  endtask

  task automatic model_step();
    for (int k = 0; k < 4; k++) begin
      exp_v[k] = game_active ? view(k, e - 1) : 4'b0000;
      if (!game_active) begin
        dead_e[k] = -1; spawn_e[k] = -1;
      end else if (dead_e[k] < 0) begin
        if (frame_tick && oob(k)) begin
          dead_e[k] = e; spawn_e[k] = -1; nw[k] = 0; ni[k] = 0;
        end
      end else if (spawn_e[k] < 0) begin
        if (e >= dead_e[k] + 2 && frame_tick) begin
          nw[k]++;
          if (nw[k] == rf[k]) spawn_e[k] = e;
        end
      end else if (inf[k] == 0) begin
        dead_e[k] = -1;
      end else if (e >= spawn_e[k] + 2 && frame_tick) begin
        ni[k]++;
        if (ni[k] == inf[k]) dead_e[k] = -1;
      end
    end
  endtask

  task automatic chk(string name, int got, int expv);
    total++;
    if (got != expv) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", name, got, expv);
    end
  endtask

  task automatic edge_step();
    @(posedge clk);
    e++;
    model_step();
    #1;
  endtask

  task automatic cyc(input logic t);
    frame_tick = t;
    edge_step();
    for (int k = 0; k < 4; k++) chk($sformatf("model_ch%0d_e%0d", k, e), int'(act(k)), int'(exp_v[k]));
  endtask

  task automatic async_reset(string name);
    #2 reset_n = 1'b0;
    model_clear();
    #1;
    chk(name, int'({act(0), act(1), act(2), act(3)}), 0);
    #2 reset_n = 1'b1;
  endtask

  typedef struct {
    logic       t;
    logic       ga;
    logic [9:0] x1, y1, x2, y2;
    logic [7:0] exp;
  } vec_t;
  vec_t tbl[16];

  int t0, tcnt, resp_e, bresp_e, inv_end, hid_t, inv_t, base, seen;
  logic tk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1);
  end

  initial begin
    // {t, ga, c1x, c1y, c2x, c2y, {d1,r1,h1,i1,d2,r2,h2,i2}}
    tbl[0]  = '{1'b1, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'h00};
    tbl[1]  = '{1'b1, 1'b1, 10'd8,   10'd471, 10'd631, 10'd0,   8'h00};
    tbl[2]  = '{1'b0, 1'b1, 10'd7,   10'd0,   10'd632, 10'd472, 8'h00};
    tbl[3]  = '{1'b1, 1'b1, 10'd300, 10'd471, 10'd300, 10'd200, 8'h00};
    tbl[4]  = '{1'b1, 1'b1, 10'd300, 10'd472, 10'd300, 10'd200, 8'h00};
    tbl[5]  = '{1'b0, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'hA0};
    tbl[6]  = '{1'b0, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'h20};
    tbl[7]  = '{1'b1, 1'b1, 10'd0,   10'd0,   10'd300, 10'd200, 8'h20};
    tbl[8]  = '{1'b1, 1'b1, 10'd300, 10'd200, 10'd640, 10'd200, 8'h20};
    tbl[9]  = '{1'b0, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'h2A};
    tbl[10] = '{1'b0, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'h22};
    tbl[11] = '{1'b0, 1'b0, 10'd300, 10'd200, 10'd300, 10'd200, 8'h00};
    tbl[12] = '{1'b1, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'h00};
    tbl[13] = '{1'b1, 1'b1, 10'd5,   10'd200, 10'd640, 10'd200, 8'h00};
    tbl[14] = '{1'b0, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'hAA};
    tbl[15] = '{1'b0, 1'b1, 10'd300, 10'd200, 10'd300, 10'd200, 8'h22};

    reset_n = 1'b0; frame_tick = 1'b0; game_active = 1'b1;
    c1x = 10'd300; c1y = 10'd200; c2x = 10'd300; c2y = 10'd200;
    model_clear();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", int'({act(0), act(1), act(2), act(3)}), 0);
    #2 reset_n = 1'b1;

    for (int i = 0; i < 10; i++) cyc(1'b1);

    for (int i = 0; i < 16; i++) begin
      frame_tick = tbl[i].t; game_active = tbl[i].ga;
      c1x = tbl[i].x1; c1y = tbl[i].y1; c2x = tbl[i].x2; c2y = tbl[i].y2;
      edge_step();
      chk($sformatf("vec%0d", i), int'({act(0), act(1)}), int'(tbl[i].exp));
    end

    // Full P1 lifecycle, frame_tick every other cycle
    game_active = 1'b1; c1x = 10'd300; c2x = 10'd300; c2y = 10'd200;
    async_reset("rst_before_life");
    c1y = 10'd472;
    cyc(1'b1);
    t0 = e; c1y = 10'd200;
    tcnt = 0; resp_e = -1; bresp_e = -1; inv_end = -1; hid_t = -1; inv_t = -1; base = 0; seen = 0;
    for (int k = 1; k <= 1000 && inv_end < 0; k++) begin
      tk = (k % 2 == 0);
      cyc(tk);
      if (b_respawn_1 && bresp_e < 0) bresp_e = e;
      if (respawn_1 && resp_e < 0) begin resp_e = e; hid_t = tcnt; base = tcnt; end
      if (invuln_1) seen = 1;
      if (seen != 0 && !invuln_1 && inv_end < 0) begin inv_end = e; inv_t = tcnt - base; end
      if (tk) tcnt++;
    end
    chk("hidden_ticks", hid_t, 120);
    chk("invuln_ticks", inv_t, 90);
    chk("respawn_edge", resp_e - t0, 241);
    chk("alive_edge", inv_end - t0, 421);
    chk("zero_delay_respawn_edge", bresp_e - t0, 3);

    // game_active dropped while WAIT counter is at 40
    async_reset("rst_before_drop");
    c1y = 10'd472;
    cyc(1'b1);
    c1y = 10'd200;
    for (int k = 1; k <= 160; k++) cyc(k % 2 == 0);
    chk("wait_hidden", int'(hidden_1), 1);
    game_active = 1'b0;
    cyc(1'b0);
    chk("drop_hidden", int'(hidden_1), 0);
    chk("drop_respawn", int'(respawn_1), 0);
    game_active = 1'b1;
    for (int k = 0; k < 6; k++) begin
      cyc(1'b1);
      chk("no_redeath", int'(death_1 | hidden_1), 0);
    end

    // Asynchronous reset in the middle of INVULN
    async_reset("rst_before_invuln");
    c1y = 10'd472;
    cyc(1'b1);
    c1y = 10'd200;
    seen = 0;
    for (int k = 1; k <= 1000 && seen < 4; k++) begin
      cyc(k % 2 == 0);
      if (invuln_1 || seen > 0) seen++;
    end
    chk("invuln_reached", int'(invuln_1), 1);
    async_reset("rst_mid_invuln");

    // Randomised play against the timeline model
    for (int i = 0; i < 6000; i++) begin
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          c1x = 10'($urandom_range(0, 1023)); c1y = 10'($urandom_range(0, 1023));
        end else begin
          c1x = 10'($urandom_range(8, 631)); c1y = 10'($urandom_range(0, 471));
        end
      end
      if ($urandom_range(0, 49) == 0) begin
        if ($urandom_range(0, 3) == 0) begin
          c2x = 10'($urandom_range(0, 1023)); c2y = 10'($urandom_range(0, 1023));
        end else begin
          c2x = 10'($urandom_range(8, 631)); c2y = 10'($urandom_range(0, 471));
        end
      end
      game_active = ($urandom_range(0, 399) != 0);
      cyc($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 1999) == 0) async_reset("rand_async_reset");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
